// File: rtl/fpd_pkg.sv
// Shared definitions for the single-precision sequential divider.
package fpd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2
  } fpd_state_t;

  localparam int EXP_BIAS = 127;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  localparam logic [31:0] INF_PATTERN = 32'h7F80_0000;

  // DIV sub-phases by counter value: one load cycle, 25 restoring steps,
  // one cycle to normalise and register the result.
  localparam logic [4:0] CNT_LOAD      = 5'd0;
  localparam logic [4:0] CNT_LAST_STEP = 5'd25;
  localparam logic [4:0] CNT_NORM      = 5'd26;

  function automatic logic [31:0] signed_inf(input logic sign);
    return INF_PATTERN | {sign, 31'b0};
  endfunction

endpackage

// File: rtl/fpd_div_step.sv
// One restoring-division step: compare, conditional subtract, shift left.
module fpd_div_step (
  input  logic [24:0] i_rem,
  input  logic [24:0] i_div,
  output logic        o_qbit,
  output logic [24:0] o_rem_nxt
);

  logic [24:0] w_diff;
  logic [24:0] w_sel;

  // Remainder stays below 2*divisor, so the shifted value always fits in 25 bits.
  always_comb begin
    w_diff    = i_rem - i_div;
    o_qbit    = (i_rem >= i_div);
    w_sel     = o_qbit ? w_diff : i_rem;
    o_rem_nxt = w_sel << 1;
  end

endmodule

// File: rtl/fpd_seq.sv
// Sequential IEEE-754 single-precision divider, fixed 27-cycle latency.
//
// state | meaning
// IDLE  | waiting for start; operands latched on acceptance
// DIV   | cnt 0: load remainder, cnt 1..25: one quotient bit per cycle,
//       | cnt 26: normalise and register the result
// NORM  | done pulse; out valid
module fpd_seq
  import fpd_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic [31:0] out
);

  localparam logic signed [9:0] BIAS_S = 10'(EXP_BIAS);

  fpd_state_t r_state;
  fpd_state_t w_state_nxt;

  logic               r_sign;
  logic [7:0]         r_e1;
  logic [7:0]         r_e2;
  logic [23:0]        r_m1;
  logic [23:0]        r_m2;
  logic [24:0]        r_rem;
  logic [24:0]        r_q;
  logic [4:0]         r_cnt;
  logic [31:0]        r_out;

  logic               w_qbit;
  logic [24:0]        w_rem_nxt;
  logic signed [9:0]  w_e1;
  logic signed [9:0]  w_e2;
  logic signed [9:0]  w_exp;
  logic [22:0]        w_mant;
  logic [31:0]        w_norm;

  fpd_div_step u_step (
    .i_rem     (r_rem),
    .i_div     ({1'b0, r_m2}),
    .o_qbit    (w_qbit),
    .o_rem_nxt (w_rem_nxt)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_DIV;
      ST_DIV:  if (r_cnt == CNT_NORM) w_state_nxt = ST_NORM;
      ST_NORM: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; result register drives out directly.
  always_comb begin
    busy = (r_state == ST_DIV);
    done = (r_state == ST_NORM);
    out  = r_out;
  end

  // Operand latch, iteration counter, restoring-division registers and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sign <= 1'b0;
      r_e1   <= '0;
      r_e2   <= '0;
      r_m1   <= '0;
      r_m2   <= '0;
      r_rem  <= '0;
      r_q    <= '0;
      r_cnt  <= '0;
      r_out  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_sign <= in1[SIGN_BIT] ^ in2[SIGN_BIT];
            r_e1   <= in1[EXP_MSB:EXP_LSB];
            r_e2   <= in2[EXP_MSB:EXP_LSB];
            r_m1   <= {1'b1, in1[MANT_MSB:0]};
            r_m2   <= {1'b1, in2[MANT_MSB:0]};
            r_cnt  <= '0;
          end
        end
        ST_DIV: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == CNT_LOAD) begin
            r_rem <= {1'b0, r_m1};
            r_q   <= '0;
          end else if (r_cnt <= CNT_LAST_STEP) begin
            r_rem <= w_rem_nxt;
            r_q   <= {r_q[23:0], w_qbit};
          end else if (r_cnt == CNT_NORM) begin
            r_out <= w_norm;
          end
        end
        default: ;
      endcase
    end
  end

  // Normalise the 25-bit quotient and apply zero/overflow/underflow rules.
  always_comb begin
    w_e1 = signed'({2'b00, r_e1});
    w_e2 = signed'({2'b00, r_e2});
    if (r_q[24]) begin
      w_mant = r_q[23:1];
      w_exp  = w_e1 - w_e2 + BIAS_S;
    end else begin
      w_mant = r_q[22:0];
      w_exp  = w_e1 - w_e2 + BIAS_S - 10'sd1;
    end
    w_norm = {r_sign, w_exp[7:0], w_mant};
    if (r_e1 == 8'd0)            w_norm = '0;
    else if (r_e2 == 8'd0)       w_norm = signed_inf(r_sign);
    else if (w_exp >= 10'sd255)  w_norm = signed_inf(r_sign);
    else if (w_exp <= 10'sd0)    w_norm = '0;
  end

endmodule

// File: tb/tb_fpd_seq.sv
// Scoreboard bench for fpd_seq: stimulus pushes expected results, a monitor
// pops and compares on done, and tracks busy and out-hold every cycle.
module tb_fpd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        done;
  logic [31:0] out;

  fpd_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .in1   (in1),
    .in2   (in2),
    .busy  (busy),
    .done  (done),
    .out   (out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] model_out = 32'h0;
  int          model_acc = -1000;

  // Quotient from real-number rules: floor(m1 * 2^24 / m2), then pack.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic              s;
    int                e1, e2, e;
    longint unsigned   m1, m2, q;
    logic [22:0]       mant;
    s  = a[31] ^ b[31];
    e1 = int'(a[30:23]);
    e2 = int'(b[30:23]);
    if (e1 == 0) return 32'h0;
    if (e2 == 0) return {s, 8'hFF, 23'h0};
    m1 = longint'({1'b1, a[22:0]});
    m2 = longint'({1'b1, b[22:0]});
    q  = (m1 << 24) / m2;
    if (q >= 64'd16777216) begin
      mant = 23'(q >> 1);
      e    = e1 - e2 + 127;
    end else begin
      mant = 23'(q);
      e    = e1 - e2 + 126;
    end
    if (e >= 255) return {s, 8'hFF, 23'h0};
    if (e <= 0)   return 32'h0;
    return {s, 8'(e), mant};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare on done, otherwise require out to hold its last value.
  always @(negedge clk) begin
    exp_t e;
    chk("busy", {31'b0, busy}, (cyc >= model_acc && cyc <= model_acc + 26) ? 32'd1 : 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out", out, e.val);
        chk("latency", 32'(cyc), 32'(e.due));
        model_out = e.val;
      end
    end else begin
      chk("out_hold", out, model_out);
      if (sb.size() > 0 && cyc > sb[0].due) begin
        chk("missing_done", {31'b0, done}, 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // Drive start for one cycle from a negedge; accepted starts enter the scoreboard.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input bit accept);
    exp_t e;
    start = 1'b1;
    in1   = a;
    in2   = b;
    if (accept) begin
      model_acc = cyc + 1;
      e.val = ref_div(a, b);
      e.due = cyc + 1 + 27;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    in1   = $urandom;
    in2   = $urandom;
  endtask

  // Return at the negedge of the first idle cycle after the current operation.
  task automatic wait_idle();
    for (int k = 0; k < 60 && cyc < model_acc + 28; k++) @(negedge clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b);
    issue(a, b, 1'b1);
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          acc;
    int          cls;
    logic [31:0] a, b;

    rst_n = 1'b0;
    start = 1'b0;
    in1   = 32'h0;
    in2   = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_out",  out, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run(32'h40C0_0000, 32'h4000_0000);
    run(32'h3F80_0000, 32'h4040_0000);
    run(32'hC000_0000, 32'h0000_0000);
    run(32'h0000_0000, 32'h4000_0000);
    run(32'h0000_0000, 32'h0000_0000);
    run(32'h7F00_0000, 32'h3E80_0000);
    run(32'h0080_0000, 32'h7F00_0000);

    // Starts during DIV and during the done cycle are ignored; the next cycle is accepted.
    issue(32'h4120_0000, 32'h4080_0000, 1'b1);
    acc = model_acc;
    while (cyc < acc + 5) @(negedge clk);
    issue(32'h3F80_0000, 32'h3F80_0000, 1'b0);
    while (cyc < acc + 27) @(negedge clk);
    issue(32'hBF80_0000, 32'h4000_0000, 1'b0);
    issue(32'hC2C8_0000, 32'h4120_0000, 1'b1);
    wait_idle();

    // Reset during cycle 10 aborts without done and clears out.
    issue(32'h4040_0000, 32'h3F00_0000, 1'b1);
    acc = model_acc;
    while (cyc < acc + 10) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb.delete();
    model_acc = -1000;
    model_out = 32'h0;
    #1;
    chk("abort_out",  out, 32'h0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(32'h4049_0FDB, 32'h402D_F854);

    for (int i = 0; i < 40; i++) begin
      cls = int'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case (cls)
        0: begin a[30:23] = 8'(100 + $urandom_range(0, 54)); b[30:23] = 8'(100 + $urandom_range(0, 54)); end
        1: a[30:23] = 8'h00;
        2: b[30:23] = 8'h00;
        3: begin a[30:23] = 8'(200 + $urandom_range(0, 55)); b[30:23] = 8'($urandom_range(1, 60)); end
        4: begin a[30:23] = 8'($urandom_range(1, 40)); b[30:23] = 8'($urandom_range(200, 255)); end
        default: ;
      endcase
      run(a, b);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
